register_file: RTL and testbench
================================

Name: register_file

Overview:
- Architectural register file plus rename-status table; it is the receiving end of the reorder buffer's commit port (RF_update_*).
- Holds 32 x 32-bit registers, each with a busy bit and the RoB tag of its newest in-flight producer.
- The dispatcher renames a destination register at issue and reads source operands (value or tag) combinationally, with same-cycle commit bypass.
- Flush clears all rename state.

Parameters:
- RoB_WIDTH, 3, width of a reorder-buffer index (tag).
- REG_COUNT, 32, number of architectural registers; x0 is hardwired zero.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- rdy_in  input  1  global enable; when low, all state holds.
- flush_signal  input  1  mispredict flush from RoB.
- RF_update_en  input  1  commit write strobe.
- RF_update_reg  input  5  commit destination register.
- RF_update_index  input  RoB_WIDTH  RoB tag of the committing entry.
- RF_update_data  input  32  commit value.
- rename_en  input  1  dispatcher allocates a destination.
- rename_reg  input  5  destination register being renamed.
- rename_index  input  RoB_WIDTH  new RoB tag (RoB new_entry_index).
- rs1_addr  input  5  source-1 register.
- rs2_addr  input  5  source-2 register.
- rs1_val  output  32  source-1 value (valid when rs1_busy=0).
- rs1_busy  output  1  source-1 awaits a RoB result.
- rs1_tag  output  RoB_WIDTH  tag to wait on when rs1_busy=1.
- rs2_val  output  32  as rs1.
- rs2_busy  output  1  as rs1.
- rs2_tag  output  RoB_WIDTH  as rs1.

Behaviour:
- Reset (async, any time, including mid-operation):
  - All data = 0, busy = 0, tag = 0.
  - Read outputs therefore show val = 0, busy = 0, tag = 0.
- rdy_in = 0: no state changes. Read outputs remain combinationally valid from the held state.
- Commit (edge, RF_update_en = 1, RF_update_reg != 0):
  - data[reg] <= RF_update_data, unconditionally.
  - busy[reg] <= 0 only if busy[reg] = 1 and tag[reg] == RF_update_index. Otherwise busy/tag are unchanged, because a younger producer still owns the register.
- Rename (edge, rename_en = 1, rename_reg != 0, flush_signal = 0):
  - busy[reg] <= 1, tag[reg] <= rename_index.
- Commit and rename to the same register in the same cycle: the rename wins (busy = 1, new tag); the data write still happens.
- Flush (edge, flush_signal = 1):
  - Every busy <= 0.
  - A commit in the same cycle still writes its data.
  - rename_en is ignored.
- Writes to register 0: ignored for data, busy and tag. Reads of register 0 always return val = 0, busy = 0, tag = 0.
- Read path (combinational, zero latency), per source:
  - If busy[rs] = 0: val = data[rs], busy = 0.
  - Else if RF_update_en = 1, RF_update_reg == rs and RF_update_index == tag[rs] (bypass): val = RF_update_data, busy = 0.
  - Else: busy = 1, tag = tag[rs], val = data[rs] (stale, don't-care).
- Reads never observe a same-cycle rename; the dispatcher reads its sources before renaming its own rd.
- The bypass is not gated by flush_signal.
- Tags may alias after RoB wrap-around only if an entry is reused while still registered. The RoB guarantees this cannot happen (full stall), so no extra check is needed.

Decomposition:
- Shared package holds: REG_COUNT, the x0 constant (5'd0), and the RoB_WIDTH default shared with the RoB and dispatcher.
- One natural sub-module, rf_read_port: the combinational bypass/lookup logic, instantiated twice (rs1, rs2).

Test Plan:
- Reset then read x5/x0 -> val = 0, busy = 0. Assert rst_in mid-run (async, between edges) -> outputs return to 0 immediately.
- Rename x5 with tag 3; next cycle read x5 -> busy = 1, tag = 3. Commit x5 with tag 3, data 0xDEADBEEF, while reading x5 in the same cycle -> bypass gives val = 0xDEADBEEF, busy = 0; next cycle busy = 0 and data persists.
- Rename x7 with tag 1, then x7 with tag 4. Commit x7 with tag 1, data 0x11 -> data = 0x11 but busy = 1, tag = 4. Commit tag 4, data 0x22 -> busy = 0, val = 0x22.
- Same cycle: commit x9 with tag 2 (busy with tag 2) and rename x9 with tag 6 -> busy = 1, tag = 6, data updated.
- Rename x1 (tag 0), x2 (tag 1), then flush together with commit x3 data 0x55 -> all busy = 0, x3 = 0x55, no new renames.
- Rename and commit to x0 with data 0x99 -> x0 reads 0, busy = 0. With rdy_in = 0, rename and commit are ignored and state holds.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared constants for the register file, the reorder buffer and the dispatcher.
package register_file_pkg;
  localparam int         ROB_W_DEFAULT = 3;
  localparam int         NUM_REGS      = 32;
  localparam int         XLEN          = 32;
  localparam logic [4:0] REG_X0        = 5'd0;
endpackage

// File: rtl/register_file_if.sv
// Commit, rename and operand-read signals between RoB/dispatcher (master) and register file (slave).
interface register_file_if #(
  parameter int RoB_WIDTH = register_file_pkg::ROB_W_DEFAULT
) ();
  logic                 RF_update_en;
  logic [4:0]           RF_update_reg;
  logic [RoB_WIDTH-1:0] RF_update_index;
  logic [31:0]          RF_update_data;
  logic                 rename_en;
  logic [4:0]           rename_reg;
  logic [RoB_WIDTH-1:0] rename_index;
  logic [4:0]           rs1_addr;
  logic [4:0]           rs2_addr;
  logic [31:0]          rs1_val;
  logic                 rs1_busy;
  logic [RoB_WIDTH-1:0] rs1_tag;
  logic [31:0]          rs2_val;
  logic                 rs2_busy;
  logic [RoB_WIDTH-1:0] rs2_tag;

  modport master (
    output RF_update_en, RF_update_reg, RF_update_index, RF_update_data,
    output rename_en, rename_reg, rename_index, rs1_addr, rs2_addr,
    input  rs1_val, rs1_busy, rs1_tag, rs2_val, rs2_busy, rs2_tag
  );

  modport slave (
    input  RF_update_en, RF_update_reg, RF_update_index, RF_update_data,
    input  rename_en, rename_reg, rename_index, rs1_addr, rs2_addr,
    output rs1_val, rs1_busy, rs1_tag, rs2_val, rs2_busy, rs2_tag
  );
endinterface

// File: rtl/register_file_rf_read_port.sv
// One source-operand lookup: stored value, or the same-cycle commit value when it
// retires the producer this register is waiting on, otherwise the tag to wait for.
module rf_read_port
  import register_file_pkg::*;
#(
  parameter int RoB_WIDTH = ROB_W_DEFAULT
) (
  input  logic [4:0]           addr,
  input  logic [XLEN-1:0]      data_in,
  input  logic                 busy_in,
  input  logic [RoB_WIDTH-1:0] tag_in,
  input  logic                 upd_en,
  input  logic [4:0]           upd_reg,
  input  logic [RoB_WIDTH-1:0] upd_index,
  input  logic [XLEN-1:0]      upd_data,
  output logic [XLEN-1:0]      val,
  output logic                 busy,
  output logic [RoB_WIDTH-1:0] tag
);
  always_comb begin
    val  = data_in;
    busy = 1'b0;
    tag  = tag_in;
    if (addr == REG_X0) begin
      val = '0;
      tag = '0;
    end else if (busy_in) begin
      if (upd_en && (upd_reg == addr) && (upd_index == tag_in)) begin
        val = upd_data;
      end else begin
        busy = 1'b1;
      end
    end
  end
endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register busy bit and newest-producer RoB tag.
module register_file
  import register_file_pkg::*;
#(
  parameter int RoB_WIDTH = ROB_W_DEFAULT,
  parameter int REG_COUNT = NUM_REGS
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           flush_signal,
  register_file_if.slave rf
);
  logic [XLEN-1:0]      data_q [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q;
  logic [RoB_WIDTH-1:0] tag_q  [REG_COUNT];

  // x0 is never written, so it keeps its reset contents forever.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < REG_COUNT; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else if (rdy_in) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        if (rf.RF_update_en && (rf.RF_update_reg == 5'(i))) begin
          data_q[i] <= rf.RF_update_data;
        end
        // A same-cycle rename outranks the commit: the register gets a younger owner.
        if (flush_signal) begin
          busy_q[i] <= 1'b0;
        end else if (rf.rename_en && (rf.rename_reg == 5'(i))) begin
          busy_q[i] <= 1'b1;
          tag_q[i]  <= rf.rename_index;
        end else if (rf.RF_update_en && (rf.RF_update_reg == 5'(i)) &&
                     busy_q[i] && (tag_q[i] == rf.RF_update_index)) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  rf_read_port #(.RoB_WIDTH(RoB_WIDTH)) u_rs1 (
    .addr      (rf.rs1_addr),
    .data_in   (data_q[rf.rs1_addr]),
    .busy_in   (busy_q[rf.rs1_addr]),
    .tag_in    (tag_q[rf.rs1_addr]),
    .upd_en    (rf.RF_update_en),
    .upd_reg   (rf.RF_update_reg),
    .upd_index (rf.RF_update_index),
    .upd_data  (rf.RF_update_data),
    .val       (rf.rs1_val),
    .busy      (rf.rs1_busy),
    .tag       (rf.rs1_tag)
  );

  rf_read_port #(.RoB_WIDTH(RoB_WIDTH)) u_rs2 (
    .addr      (rf.rs2_addr),
    .data_in   (data_q[rf.rs2_addr]),
    .busy_in   (busy_q[rf.rs2_addr]),
    .tag_in    (tag_q[rf.rs2_addr]),
    .upd_en    (rf.RF_update_en),
    .upd_reg   (rf.RF_update_reg),
    .upd_index (rf.RF_update_index),
    .upd_data  (rf.RF_update_data),
    .val       (rf.rs2_val),
    .busy      (rf.rs2_busy),
    .tag       (rf.rs2_tag)
  );
endmodule

// File: tb/tb_register_file.sv
// Directed vector bench for register_file: commit/rename/flush/bypass and async reset.
module tb_register_file;
  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic flush_signal;

  register_file_if rf_bus ();

  register_file dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .flush_signal (flush_signal),
    .rf           (rf_bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        ue;
    logic [4:0]  ur;
    logic [2:0]  ui;
    logic [31:0] ud;
    logic        re;
    logic [4:0]  rr;
    logic [2:0]  ri;
    logic        fl;
    logic        rdy;
    logic [4:0]  a1;
    logic [31:0] v1;
    logic        b1;
    logic [2:0]  t1;
    logic        cv1;
    logic        ct1;
    logic [4:0]  a2;
    logic [31:0] v2;
    logic        b2;
    logic [2:0]  t2;
    logic        cv2;
    logic        ct2;
  } vec_t;

  vec_t  vecs[$];
  string names[$];
  int    checks   = 0;
  int    failures = 0;

  task automatic add(input string n,
                     input logic ue, input logic [4:0] ur, input logic [2:0] ui, input logic [31:0] ud,
                     input logic re, input logic [4:0] rr, input logic [2:0] ri,
                     input logic fl, input logic rdy,
                     input logic [4:0] a1, input logic [31:0] v1, input logic b1, input logic [2:0] t1,
                     input logic cv1, input logic ct1,
                     input logic [4:0] a2, input logic [31:0] v2, input logic b2, input logic [2:0] t2,
                     input logic cv2, input logic ct2);
    vec_t v;
    v.ue = ue; v.ur = ur; v.ui = ui; v.ud = ud;
    v.re = re; v.rr = rr; v.ri = ri; v.fl = fl; v.rdy = rdy;
    v.a1 = a1; v.v1 = v1; v.b1 = b1; v.t1 = t1; v.cv1 = cv1; v.ct1 = ct1;
    v.a2 = a2; v.v2 = v2; v.b2 = b2; v.t2 = t2; v.cv2 = cv2; v.ct2 = ct2;
    vecs.push_back(v);
    names.push_back(n);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rf_bus.RF_update_en    = 1'b0;
    rf_bus.RF_update_reg   = '0;
    rf_bus.RF_update_index = '0;
    rf_bus.RF_update_data  = '0;
    rf_bus.rename_en       = 1'b0;
    rf_bus.rename_reg      = '0;
    rf_bus.rename_index    = '0;
    flush_signal           = 1'b0;
    rdy_in                 = 1'b1;
  endtask

  initial begin
    rst_in = 1'b1;
    idle_inputs();
    rf_bus.rs1_addr = 5'd5;
    rf_bus.rs2_addr = 5'd0;
    #2;
    chk("in_reset_rs1_val",  rf_bus.rs1_val, 32'h0);
    chk("in_reset_rs1_busy", 32'(rf_bus.rs1_busy), 32'h0);
    chk("in_reset_rs2_busy", 32'(rf_bus.rs2_busy), 32'h0);
    #10 rst_in = 1'b0;

    //   name             ue ur ui ud            re rr ri fl rdy  a1 v1            b1 t1 cv ct  a2 v2            b2 t2 cv ct
    add("rst_read",       0, 0, 0, 32'h0,        0, 0, 0, 0, 1,   5, 32'h0,        0, 0, 1, 1,  0, 32'h0,        0, 0, 1, 1);
    add("ren_x5",         0, 0, 0, 32'h0,        1, 5, 3, 0, 1,   5, 32'h0,        0, 0, 1, 1,  0, 32'h0,        0, 0, 1, 1);
    add("x5_busy",        0, 0, 0, 32'h0,        0, 0, 0, 0, 1,   5, 32'h0,        1, 3, 0, 1,  0, 32'h0,        0, 0, 1, 1);
    add("x5_bypass",      1, 5, 3, 32'hDEADBEEF, 0, 0, 0, 0, 1,   5, 32'hDEADBEEF, 0, 0, 1, 0,  5, 32'hDEADBEEF, 0, 0, 1, 0);
    add("x5_persist",     0, 0, 0, 32'h0,        0, 0, 0, 0, 1,   5, 32'hDEADBEEF, 0, 0, 1, 0,  0, 32'h0,        0, 0, 1, 1);
    add("ren_x7_t1",      0, 0, 0, 32'h0,        1, 7, 1, 0, 1,   7, 32'h0,        0, 0, 1, 1,  5, 32'hDEADBEEF, 0, 0, 1, 0);
    add("ren_x7_t4",      0, 0, 0, 32'h0,        1, 7, 4, 0, 1,   7, 32'h0,        1, 1, 0, 1,  0, 32'h0,        0, 0, 1, 1);
    add("x7_old_commit",  1, 7, 1, 32'h11,       0, 0, 0, 0, 1,   7, 32'h0,        1, 4, 0, 1,  0, 32'h0,        0, 0, 1, 1);
    add("x7_stale",       0, 0, 0, 32'h0,        0, 0, 0, 0, 1,   7, 32'h11,       1, 4, 1, 1,  0, 32'h0,        0, 0, 1, 1);
    add("x7_new_commit",  1, 7, 4, 32'h22,       0, 0, 0, 0, 1,   7, 32'h22,       0, 0, 1, 0,  7, 32'h22,       0, 0, 1, 0);
    add("x7_done",        0, 0, 0, 32'h0,        0, 0, 0, 0, 1,   7, 32'h22,       0, 0, 1, 0,  0, 32'h0,        0, 0, 1, 1);
    add("ren_x9_t2",      0, 0, 0, 32'h0,        1, 9, 2, 0, 1,   9, 32'h0,        0, 0, 1, 1,  0, 32'h0,        0, 0, 1, 1);
    add("x9_commit_ren",  1, 9, 2, 32'h900D,     1, 9, 6, 0, 1,   9, 32'h900D,     0, 0, 1, 0,  0, 32'h0,        0, 0, 1, 1);
    add("x9_after",       0, 0, 0, 32'h0,        0, 0, 0, 0, 1,   9, 32'h900D,     1, 6, 1, 1,  0, 32'h0,        0, 0, 1, 1);
    add("ren_x1",         0, 0, 0, 32'h0,        1, 1, 0, 0, 1,   1, 32'h0,        0, 0, 1, 1,  2, 32'h0,        0, 0, 1, 1);
    add("ren_x2",         0, 0, 0, 32'h0,        1, 2, 1, 0, 1,   1, 32'h0,        1, 0, 0, 1,  2, 32'h0,        0, 0, 1, 1);
    add("flush_commit",   1, 3, 5, 32'h55,       1, 4, 7, 1, 1,   1, 32'h0,        1, 0, 0, 1,  2, 32'h0,        1, 1, 0, 1);
    add("post_flush_a",   0, 0, 0, 32'h0,        0, 0, 0, 0, 1,   1, 32'h0,        0, 0, 1, 0,  2, 32'h0,        0, 0, 1, 0);
    add("post_flush_b",   0, 0, 0, 32'h0,        0, 0, 0, 0, 1,   3, 32'h55,       0, 0, 1, 0,  4, 32'h0,        0, 0, 1, 1);
    add("post_flush_c",   0, 0, 0, 32'h0,        0, 0, 0, 0, 1,   9, 32'h900D,     0, 0, 1, 0,  7, 32'h22,       0, 0, 1, 0);
    add("x0_write",       1, 0, 0, 32'h99,       1, 0, 5, 0, 1,   0, 32'h0,        0, 0, 1, 1,  0, 32'h0,        0, 0, 1, 1);
    add("x0_after",       0, 0, 0, 32'h0,        0, 0, 0, 0, 1,   0, 32'h0,        0, 0, 1, 1,  0, 32'h0,        0, 0, 1, 1);
    add("rdy_low",        1, 3, 0, 32'hAAAA,     1, 3, 2, 0, 0,   3, 32'h55,       0, 0, 1, 0,  3, 32'h55,       0, 0, 1, 0);
    add("rdy_hold",       0, 0, 0, 32'h0,        0, 0, 0, 0, 1,   3, 32'h55,       0, 0, 1, 1,  0, 32'h0,        0, 0, 1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_in);
      rf_bus.RF_update_en    = vecs[i].ue;
      rf_bus.RF_update_reg   = vecs[i].ur;
      rf_bus.RF_update_index = vecs[i].ui;
      rf_bus.RF_update_data  = vecs[i].ud;
      rf_bus.rename_en       = vecs[i].re;
      rf_bus.rename_reg      = vecs[i].rr;
      rf_bus.rename_index    = vecs[i].ri;
      flush_signal           = vecs[i].fl;
      rdy_in                 = vecs[i].rdy;
      rf_bus.rs1_addr        = vecs[i].a1;
      rf_bus.rs2_addr        = vecs[i].a2;
      #1;
      chk({names[i], "_rs1_busy"}, 32'(rf_bus.rs1_busy), 32'(vecs[i].b1));
      chk({names[i], "_rs2_busy"}, 32'(rf_bus.rs2_busy), 32'(vecs[i].b2));
      if (vecs[i].cv1) chk({names[i], "_rs1_val"}, rf_bus.rs1_val, vecs[i].v1);
      if (vecs[i].ct1) chk({names[i], "_rs1_tag"}, 32'(rf_bus.rs1_tag), 32'(vecs[i].t1));
      if (vecs[i].cv2) chk({names[i], "_rs2_val"}, rf_bus.rs2_val, vecs[i].v2);
      if (vecs[i].ct2) chk({names[i], "_rs2_tag"}, 32'(rf_bus.rs2_tag), 32'(vecs[i].t2));
    end

    // Asynchronous reset between clock edges with live state.
    @(negedge clk_in);
    idle_inputs();
    rf_bus.rename_en       = 1'b1;
    rf_bus.rename_reg      = 5'd6;
    rf_bus.rename_index    = 3'd2;
    rf_bus.RF_update_en    = 1'b1;
    rf_bus.RF_update_reg   = 5'd10;
    rf_bus.RF_update_data  = 32'h1234;
    @(negedge clk_in);
    idle_inputs();
    rf_bus.rs1_addr = 5'd10;
    rf_bus.rs2_addr = 5'd6;
    #1;
    chk("pre_rst_rs1_val",  rf_bus.rs1_val, 32'h1234);
    chk("pre_rst_rs2_busy", 32'(rf_bus.rs2_busy), 32'h1);
    chk("pre_rst_rs2_tag",  32'(rf_bus.rs2_tag), 32'h2);
    #1 rst_in = 1'b1;
    #1;
    chk("async_rst_rs1_val",  rf_bus.rs1_val, 32'h0);
    chk("async_rst_rs2_busy", 32'(rf_bus.rs2_busy), 32'h0);
    chk("async_rst_rs2_tag",  32'(rf_bus.rs2_tag), 32'h0);
    rst_in = 1'b0;
    @(negedge clk_in);
    #1;
    chk("post_rst_rs1_val",  rf_bus.rs1_val, 32'h0);
    chk("post_rst_rs2_busy", 32'(rf_bus.rs2_busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
